// File: rtl/rf_wb_arbiter_pkg.sv
// Shared writeback definitions: source ids, request record, default widths.
// No logic; used by the arbiter, its FIFOs and the port interface.
// Widths default to the register file address and SIMD data widths.
package rf_wb_arbiter_pkg;

    localparam int RF_ADDR_WIDTH   = 5;
    localparam int SIMD_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_LSU = 2'd1,
        WB_SRC_MDU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0]   rd;
        logic [SIMD_DATA_WIDTH-1:0] data;
        logic                       simd;
    } wb_req_t;

    // The buffered requester that is not s (LSU <-> MDU).
    function automatic wb_src_e otherSrc(input wb_src_e s);
        return (s == WB_SRC_LSU) ? WB_SRC_MDU : WB_SRC_LSU;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bundle: producer requests in, register file write ports and pending mask out.
// master = producers/register file side, slave = the arbiter.
// Only ALU is never back-pressured; LSU/MDU use valid/ready.
interface rf_wb_arbiter_if
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = SIMD_DATA_WIDTH,
    parameter int ADDR_W = RF_ADDR_WIDTH
);
    logic                     flush;
    logic                     alu_valid;
    logic [ADDR_W-1:0]        alu_rd;
    logic [DATA_W-1:0]        alu_data;
    logic                     alu_simd;
    logic                     lsu_valid;
    logic                     lsu_ready;
    logic [ADDR_W-1:0]        lsu_rd;
    logic [DATA_W-1:0]        lsu_data;
    logic                     lsu_simd;
    logic                     mdu_valid;
    logic                     mdu_ready;
    logic [ADDR_W-1:0]        mdu_rd;
    logic [DATA_W-1:0]        mdu_data;
    logic                     mdu_simd;
    logic                     wen1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     simd1;
    logic                     wen2;
    logic [ADDR_W-1:0]        waddr2;
    logic [DATA_W-1:0]        wdata2;
    logic                     simd2;
    logic [(1<<ADDR_W)-1:0]   pending_mask;

    modport master (
        output flush,
        output alu_valid, alu_rd, alu_data, alu_simd,
        output lsu_valid, lsu_rd, lsu_data, lsu_simd, input lsu_ready,
        output mdu_valid, mdu_rd, mdu_data, mdu_simd, input mdu_ready,
        input  wen1, waddr1, wdata1, simd1,
        input  wen2, waddr2, wdata2, simd2,
        input  pending_mask
    );

    modport slave (
        input  flush,
        input  alu_valid, alu_rd, alu_data, alu_simd,
        input  lsu_valid, lsu_rd, lsu_data, lsu_simd, output lsu_ready,
        input  mdu_valid, mdu_rd, mdu_data, mdu_simd, output mdu_ready,
        output wen1, waddr1, wdata1, simd1,
        output wen2, waddr2, wdata2, simd2,
        output pending_mask
    );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding buffered writeback requests (rd/data/simd).
// Latency: push at t, head visible at t+1; flush empties it in one cycle.
// No internal backpressure: caller pushes only when !full and pops only when !empty.
// RF_WB_PENDING_MASK_EN adds a per-entry rd view (invalid slots read as x0).
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushRd,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pushSimd,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] headRd,
    output logic [DATA_W-1:0] headData,
    output logic              headSimd
`ifdef RF_WB_PENDING_MASK_EN
    ,
    output logic [ADDR_W-1:0] entryRd [DEPTH]
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rdMem   [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic              simdMem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W:0]    count;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign headRd   = rdMem[rdPtr];
    assign headData = dataMem[rdPtr];
    assign headSimd = simdMem[rdPtr];

    // Pointer and occupancy tracking; flush discards everything at once.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            rdMem[wrPtr]   <= pushRd;
            dataMem[wrPtr] <= pushData;
            simdMem[wrPtr] <= pushSimd;
        end
    end

`ifdef RF_WB_PENDING_MASK_EN
    // Expose occupied slots' rd; empty slots report x0 so they never mark a register.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off        = PTR_W'(i) - rdPtr;
            entryRd[i] = ({1'b0, off} < count) ? rdMem[i] : '0;
        end
    end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback scheduler: ALU direct, LSU/MDU buffered + round-robin, onto two RF write ports.
// Latency: ALU request t -> wen at t+1; LSU/MDU push t -> earliest wen at t+2.
// LSU/MDU ready = !full (no pass-through when full); ALU never stalled. RF_WB_PENDING_MASK_EN enables pending_mask.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = SIMD_DATA_WIDTH,
    parameter int ADDR_W     = RF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);
    logic              rstDone;
    wb_src_e           rrPtr;
    logic              lsuFull, lsuEmpty, lsuHeadSimd, lsuPush, lsuPop;
    logic              mduFull, mduEmpty, mduHeadSimd, mduPush, mduPop;
    logic [ADDR_W-1:0] lsuHeadRd, mduHeadRd;
    logic [DATA_W-1:0] lsuHeadData, mduHeadData;
`ifdef RF_WB_PENDING_MASK_EN
    logic [ADDR_W-1:0] lsuEntryRd [FIFO_DEPTH];
    logic [ADDR_W-1:0] mduEntryRd [FIFO_DEPTH];
`endif

    // Ready is held low during reset and the cycle that leaves it.
    assign bus.lsu_ready = rstDone && !lsuFull;
    assign bus.mdu_ready = rstDone && !mduFull;
    assign lsuPush = bus.lsu_valid && bus.lsu_ready && !bus.flush;
    assign mduPush = bus.mdu_valid && bus.mdu_ready && !bus.flush;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) lsuFifo (
        .clk(clk), .rst_n(rst_n), .flush(bus.flush),
        .push(lsuPush), .pushRd(bus.lsu_rd), .pushData(bus.lsu_data), .pushSimd(bus.lsu_simd),
        .pop(lsuPop), .full(lsuFull), .empty(lsuEmpty),
        .headRd(lsuHeadRd), .headData(lsuHeadData), .headSimd(lsuHeadSimd)
`ifdef RF_WB_PENDING_MASK_EN
        , .entryRd(lsuEntryRd)
`endif
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) mduFifo (
        .clk(clk), .rst_n(rst_n), .flush(bus.flush),
        .push(mduPush), .pushRd(bus.mdu_rd), .pushData(bus.mdu_data), .pushSimd(bus.mdu_simd),
        .pop(mduPop), .full(mduFull), .empty(mduEmpty),
        .headRd(mduHeadRd), .headData(mduHeadData), .headSimd(mduHeadSimd)
`ifdef RF_WB_PENDING_MASK_EN
        , .entryRd(mduEntryRd)
`endif
    );

    // x0 requests never compete for a port; buffered x0 heads are just dropped.
    logic aluW, lsuCand, mduCand, lsuX0, mduX0;
    assign aluW    = bus.alu_valid && (bus.alu_rd != '0);
    assign lsuCand = !lsuEmpty && (lsuHeadRd != '0);
    assign mduCand = !mduEmpty && (mduHeadRd != '0);
    assign lsuX0   = !lsuEmpty && (lsuHeadRd == '0);
    assign mduX0   = !mduEmpty && (mduHeadRd == '0);

    // A is the favoured buffered requester this cycle, B the other one.
    wb_src_e           srcA, srcB;
    logic              candA, candB, grantA, grantB;
    logic [ADDR_W-1:0] rdA, rdB;
    assign srcA  = rrPtr;
    assign srcB  = otherSrc(rrPtr);
    assign candA = (srcA == WB_SRC_LSU) ? lsuCand   : mduCand;
    assign candB = (srcA == WB_SRC_LSU) ? mduCand   : lsuCand;
    assign rdA   = (srcA == WB_SRC_LSU) ? lsuHeadRd : mduHeadRd;
    assign rdB   = (srcA == WB_SRC_LSU) ? mduHeadRd : lsuHeadRd;

    // Fill slots: ALU first, then A, then B; a second write to the first rd is skipped.
    logic    p1Vld, p2Vld;
    wb_src_e p1Src, p2Src;
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        p1Vld  = 1'b0;
        p2Vld  = 1'b0;
        p1Src  = WB_SRC_ALU;
        p2Src  = WB_SRC_ALU;
        if (aluW) begin
            p1Vld = 1'b1;
            if (candA && rdA != bus.alu_rd) begin
                grantA = 1'b1; p2Vld = 1'b1; p2Src = srcA;
            end else if (candB && rdB != bus.alu_rd) begin
                grantB = 1'b1; p2Vld = 1'b1; p2Src = srcB;
            end
        end else if (candA) begin
            grantA = 1'b1; p1Vld = 1'b1; p1Src = srcA;
            if (candB && rdB != rdA) begin
                grantB = 1'b1; p2Vld = 1'b1; p2Src = srcB;
            end
        end else if (candB) begin
            grantB = 1'b1; p1Vld = 1'b1; p1Src = srcB;
        end
    end

    logic lsuGrant, mduGrant;
    assign lsuGrant = (srcA == WB_SRC_LSU) ? grantA : grantB;
    assign mduGrant = (srcA == WB_SRC_LSU) ? grantB : grantA;
    assign lsuPop   = lsuGrant || lsuX0;
    assign mduPop   = mduGrant || mduX0;

    // Steer the chosen source's fields onto each write port.
    logic [ADDR_W-1:0] p1Rd, p2Rd;
    logic [DATA_W-1:0] p1Data, p2Data;
    logic              p1Simd, p2Simd;
    always_comb begin
        case (p1Src)
            WB_SRC_LSU: {p1Rd, p1Data, p1Simd} = {lsuHeadRd, lsuHeadData, lsuHeadSimd};
            WB_SRC_MDU: {p1Rd, p1Data, p1Simd} = {mduHeadRd, mduHeadData, mduHeadSimd};
            default:    {p1Rd, p1Data, p1Simd} = {bus.alu_rd, bus.alu_data, bus.alu_simd};
        endcase
        case (p2Src)
            WB_SRC_LSU: {p2Rd, p2Data, p2Simd} = {lsuHeadRd, lsuHeadData, lsuHeadSimd};
            WB_SRC_MDU: {p2Rd, p2Data, p2Simd} = {mduHeadRd, mduHeadData, mduHeadSimd};
            default:    {p2Rd, p2Data, p2Simd} = {bus.alu_rd, bus.alu_data, bus.alu_simd};
        endcase
    end

    // Register the write ports and advance round-robin; flush only silences the ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstDone    <= 1'b0;
            rrPtr      <= WB_SRC_LSU;
            bus.wen1   <= 1'b0;
            bus.waddr1 <= '0;
            bus.wdata1 <= '0;
            bus.simd1  <= 1'b0;
            bus.wen2   <= 1'b0;
            bus.waddr2 <= '0;
            bus.wdata2 <= '0;
            bus.simd2  <= 1'b0;
        end else begin
            rstDone <= 1'b1;
            if (bus.flush) begin
                bus.wen1 <= 1'b0;
                bus.wen2 <= 1'b0;
            end else begin
                bus.wen1   <= p1Vld;
                bus.waddr1 <= p1Rd;
                bus.wdata1 <= p1Data;
                bus.simd1  <= p1Simd;
                bus.wen2   <= p2Vld;
                bus.waddr2 <= p2Rd;
                bus.wdata2 <= p2Data;
                bus.simd2  <= p2Simd;
                if (lsuGrant && !mduGrant)      rrPtr <= WB_SRC_MDU;
                else if (mduGrant && !lsuGrant) rrPtr <= WB_SRC_LSU;
                else if (lsuGrant && mduGrant)  rrPtr <= otherSrc(rrPtr);
            end
        end
    end

`ifdef RF_WB_PENDING_MASK_EN
    // Mark every rd still queued or currently being written; x0 is never pending.
    logic [(1<<ADDR_W)-1:0] mask;
    always_comb begin
        mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mask[lsuEntryRd[i]] = 1'b1;
            mask[mduEntryRd[i]] = 1'b1;
        end
        if (bus.wen1) mask[bus.waddr1] = 1'b1;
        if (bus.wen2) mask[bus.waddr2] = 1'b1;
        mask[0] = 1'b0;
    end
    assign bus.pending_mask = mask;
`else
    assign bus.pending_mask = '0;
`endif

endmodule
